// File: rtl/srl_fifo_pkg.sv
// Shared constants and types for the SRL-based FIFO controller.
package srl_fifo_pkg;

    localparam int SRL_DEPTH = 32;
    localparam int SRL_AW    = 5;
    localparam int LVL_W     = 6;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/srl32_bank.sv
// Bank of WIDTH 32-deep addressable shift registers (one SRLC32E-style column
// per data bit) sharing shift enable and read address. No reset: contents are
// only ever exposed through the controller's valid qualification.
module srl32_bank
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              ce,
    input  logic [WIDTH-1:0]  d,
    input  logic [SRL_AW-1:0] a,
    output logic [WIDTH-1:0]  q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        logic [SRL_DEPTH-1:0] sr;

        // Shift new bit into index 0 on every enabled cycle.
        always_ff @(posedge clk) begin
            if (ce) sr <= {sr[SRL_DEPTH-2:0], d[i]};
        end

        assign q[i] = sr[a];
    end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FIFO controller sequencing an SRL bank as storage.
// Optional output register stage enabled by defining SRL_FIFO_OREG_EN
// (capacity 33, 2-cycle push-to-valid latency, registered m_data).
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int AFULL_LVL  = 28,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LVL_W-1:0] level,
    output logic             afull,
    output logic             aempty
);

    localparam logic [LVL_W-1:0] AF_LVL = LVL_W'(AFULL_LVL);
    localparam logic [LVL_W-1:0] AE_LVL = LVL_W'(AEMPTY_LVL);
    localparam logic [LVL_W-1:0] FULL_L = LVL_W'(SRL_DEPTH);

    state_t            state, state_nxt;
    logic [SRL_AW-1:0] addr, addr_nxt;
    logic [LVL_W-1:0]  srl_lvl, srl_lvl_nxt, tot_nxt;
    logic [WIDTH-1:0]  srl_q;
    logic              push, srl_pop, srl_valid;

    assign push      = s_valid & s_ready;
    assign srl_valid = (state != ST_EMPTY);

    srl32_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .ce  (push),
        .d   (s_data),
        .a   (addr),
        .q   (srl_q)
    );

`ifdef SRL_FIFO_OREG_EN
    logic ovld, ovld_nxt;

    // SRL head moves into the output register whenever it is free or draining.
    assign srl_pop  = srl_valid & (~ovld | m_ready);
    assign ovld_nxt = srl_pop | (ovld & ~m_ready);
    assign tot_nxt  = srl_lvl_nxt + LVL_W'(ovld_nxt);
    assign m_valid  = ovld;

    // Output register: holds the current head, loaded from the SRL mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovld <= 1'b0;
        end else begin
            ovld <= ovld_nxt;
            if (srl_pop) m_data <= srl_q;
        end
    end
`else
    assign srl_pop = srl_valid & m_ready;
    assign tot_nxt = srl_lvl_nxt;
    assign m_valid = srl_valid;
    assign m_data  = srl_q;
`endif

    // Next SRL occupancy and head address. Simultaneous push+pop leaves both
    // unchanged: the shift slides the next-oldest entry under addr.
    always_comb begin
        srl_lvl_nxt = srl_lvl;
        addr_nxt    = addr;
        if (push && !srl_pop) begin
            srl_lvl_nxt = srl_lvl + LVL_W'(1);
            if (srl_lvl != '0) addr_nxt = addr + SRL_AW'(1);
        end else if (!push && srl_pop) begin
            srl_lvl_nxt = srl_lvl - LVL_W'(1);
            if (srl_lvl != LVL_W'(1)) addr_nxt = addr - SRL_AW'(1);
        end
        if (srl_lvl_nxt == '0)        state_nxt = ST_EMPTY;
        else if (srl_lvl_nxt == FULL_L) state_nxt = ST_FULL;
        else                          state_nxt = ST_ACTIVE;
    end

    // FSM and registered status outputs, all updated from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            srl_lvl <= '0;
            addr    <= '0;
            s_ready <= 1'b0;
            level   <= '0;
            afull   <= 1'b0;
            aempty  <= 1'b1;
        end else begin
            state   <= state_nxt;
            srl_lvl <= srl_lvl_nxt;
            addr    <= addr_nxt;
            s_ready <= (state_nxt != ST_FULL);
            level   <= tot_nxt;
            afull   <= (tot_nxt >= AF_LVL);
            aempty  <= (tot_nxt <= AE_LVL);
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl using a data scoreboard queue.
module tb_srl_fifo_ctrl;

`ifdef SRL_FIFO_OREG_EN
    localparam int CAP = 33;
    localparam int LAT = 2;
`else
    localparam int CAP = 32;
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [5:0]  level;
    logic        afull;
    logic        aempty;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    srl_fifo_ctrl #(.WIDTH(16), .AFULL_LVL(28), .AEMPTY_LVL(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .afull   (afull),
        .aempty  (aempty)
    );

    always #5 clk = ~clk;

    // One clock: score handshakes before the edge, check status after it.
    task automatic tick();
        logic do_push, do_pop;
        int exp_lvl;
        do_pop  = m_valid && m_ready;
        do_push = s_valid && s_ready && !rst;
        if (do_pop && !rst) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: got data %h, expected no output", m_data);
            end else begin
                if (m_data !== sb[0]) begin
                    errors++;
                    $display("FAIL data_order: got %h, expected %h", m_data, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
        if (do_push) sb.push_back(s_data);
        @(posedge clk);
        #1;
        exp_lvl = sb.size();
        checks++;
        if (level !== 6'(exp_lvl)) begin
            errors++;
            $display("FAIL level: got %0d, expected %0d", level, exp_lvl);
        end
        checks++;
        if (afull !== (exp_lvl >= 28) || aempty !== (exp_lvl <= 2)) begin
            errors++;
            $display("FAIL afull_aempty: got %b/%b, expected %b/%b at level %0d",
                     afull, aempty, exp_lvl >= 28, exp_lvl <= 2, exp_lvl);
        end
`ifndef SRL_FIFO_OREG_EN
        checks++;
        if (m_valid !== (exp_lvl != 0)) begin
            errors++;
            $display("FAIL m_valid: got %b, expected %b", m_valid, exp_lvl != 0);
        end
`endif
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || m_valid) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d left m_valid %b, expected 0 left", sb.size(), m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 16'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (level !== 6'd0 || m_valid !== 1'b0 || s_ready !== 1'b0 || afull !== 1'b0 || aempty !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got lvl %0d mv %b sr %b af %b ae %b, expected 0 0 0 0 1",
                     level, m_valid, s_ready, afull, aempty);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 1", s_ready);
        end
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 1; i <= CAP + 1; i++) begin
            checks++;
            if (s_ready !== (i <= CAP)) begin
                errors++;
                $display("FAIL fill_ready: push %0d got %b, expected %b", i, s_ready, i <= CAP);
            end
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (level !== 6'(CAP) || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got lvl %0d sr %b, expected %0d 0", level, s_ready, CAP);
        end
    endtask

    task automatic test_drain();
        drain();
        checks++;
        if (level !== 6'd0 || aempty !== 1'b1) begin
            errors++;
            $display("FAIL drained: got lvl %0d ae %b, expected 0 1", level, aempty);
        end
    endtask

    task automatic test_latency();
        int n = 0;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        while (!m_valid && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if (n + 1 !== LAT || m_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL latency: got %0d cycles data %h, expected %0d cycles data beef", n + 1, m_data, LAT);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        fill(5, 16'h0100);
        repeat (2) tick();
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 16'h0200 + 16'(i);
            tick();
        end
        checks++;
        if (level !== 6'd5) begin
            errors++;
            $display("FAIL steady_level: got %0d, expected 5", level);
        end
        drain();
    endtask

    task automatic test_full_pushpop();
        fill(CAP, 16'h0300);
        repeat (2) tick();
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_before: got sr %b mv %b, expected 0 1", s_ready, m_valid);
        end
        s_valid = 1'b1; s_data = 16'hDEAD; m_ready = 1'b1;
        tick();
        s_valid = 1'b0; m_ready = 1'b0;
        checks++;
        if (level !== 6'(CAP - 1) || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: got lvl %0d sr %b, expected %0d 1", level, s_ready, CAP - 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        fill(17, 16'h0400);
        rst = 1'b1;
        sb.delete();
        tick();
        checks++;
        if (level !== 6'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got lvl %0d mv %b, expected 0 0", level, m_valid);
        end
        rst = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        s_valid = 1'b0;
        while (!m_valid && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h1234) begin
            errors++;
            $display("FAIL first_after_reset: got mv %b data %h, expected 1 1234", m_valid, m_data);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_latency();
        test_back_to_back();
        test_full_pushpop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
